baud_ctrl: RTL and testbench
============================

// Module: baud_ctrl
// PURPOSE
//  Runtime baud-rate controller for the UART. Replaces the fixed 16x sample-clock divider.
//  Generates single-cycle clock-enable strobes in the clk50 domain:
//  - 16x oversample strobe (tick16) for the receiver
//  - 1x bit strobe (tick1) for the transmitter
//  - legacy 50%-duty 16x square wave (clkout16)
//  Host requests a baud change over a req/ack handshake. The change is deferred until RX and TX are idle.
// PARAMETERS
//  DEFAULT_SEL  3'd1  baud select loaded at reset (1 = 9600)
//  CNT_W        16    divisor/counter width; must hold 651
// PORTS
//  clk50     in   1  system clock, 50 MHz
//  rst_n     in   1  asynchronous, active-low reset
//  cfg_req   in   1  1-cycle pulse; request baud change to cfg_sel
//  cfg_sel   in   3  baud select, sampled when cfg_req=1 in IDLE
//  busy_rx   in   1  receiver mid-frame; blocks apply
//  busy_tx   in   1  transmitter mid-frame; blocks apply
//  cfg_ack   out  1  1-cycle pulse; request completed (applied or rejected)
//  cfg_err   out  1  valid with cfg_ack; 1 = cfg_sel invalid, nothing changed
//  cur_sel   out  3  baud select currently in force
//  tick16    out  1  1-cycle strobe at 16x baud
//  tick1     out  1  1-cycle strobe at 1x baud, coincident with every 16th tick16
//  clkout16  out  1  ~50% duty square wave at 16x baud
// BEHAVIOUR
//  Divisor table, DIV = round(50e6/(16*baud)):
//   0: 4800 -> 651   1: 9600 -> 326   2: 19200 -> 163
//   3: 38400 -> 81   4: 57600 -> 54   5: 115200 -> 27
//   6, 7: invalid
//  Reset (async):
//   state=IDLE; div=DIV(DEFAULT_SEL); cur_sel=DEFAULT_SEL; cnt=0; sub=0
//   tick16, tick1, clkout16, cfg_ack, cfg_err = 0
//  Divider:
//   cnt counts 0..DIV-1 and wraps to 0.
//   tick16=1 in the cycle after cnt==DIV-1, i.e. one pulse every DIV clocks.
//   sub (4 bits) increments on each tick16; tick1=1 together with the tick16 that wraps sub 15->0.
//   clkout16 rises the cycle after cnt==(DIV>>1)-1 and falls the cycle after cnt==DIV-1.
//   For DIV=326: 163 cycles high, 163 low.
//  FSM states IDLE, PEND, APPLY, ACK:
//   IDLE:  cfg_req=1 -> latch cfg_sel into nsel, go to PEND. Otherwise stay.
//   PEND:  nsel invalid -> ACK with err=1.
//          else busy_rx=0 and busy_tx=0 -> APPLY.
//          else stay; waits indefinitely, divider keeps running at the old rate.
//   APPLY: div<=DIV(nsel); cur_sel<=nsel; cnt<=0; sub<=0; clkout16<=0; tick16/tick1 suppressed this cycle; -> ACK.
//   ACK:   cfg_ack=1 for exactly one cycle; cfg_err as determined; -> IDLE.
//  Handshake timing:
//   req in cycle N with busy low -> ack in cycle N+3.
//   First tick16 at the new rate comes DIV clocks after APPLY.
//  Boundary conditions:
//   - cfg_req while not IDLE: ignored, no second ack.
//   - cfg_req with cfg_sel == cur_sel: still goes through APPLY; divider phase restarts.
//   - busy toggling while in PEND: apply only in a cycle where both busy inputs are 0.
//   - rst_n asserted mid-request: request dropped, no ack, DEFAULT_SEL restored.
//   - Invalid select: div, cur_sel and the divider phase are untouched.
// TESTING
//  1. Reset release, no req -> tick16 period 326 clks; tick1 period 5216 clks; clkout16 163 high/163 low; cur_sel=1.
//  2. req sel=5, busy low at cycle N -> cfg_ack at N+3, cfg_err=0, cur_sel=5; tick16 every 27 clks; first tick 27 clks after APPLY.
//  3. busy_tx=1, req sel=0, drop busy_tx 1000 clks later -> ack 2 clks after busy drops; old rate holds until apply; then period 651.
//  4. req sel=6 -> ack at N+2, cfg_err=1; cur_sel and tick16 period unchanged (no phase glitch).
//  5. Second cfg_req while in PEND -> ignored; exactly one ack, using the first cfg_sel.
//  6. rst_n low during PEND -> no ack; after release cur_sel=DEFAULT_SEL, period 326.

Source files
------------

// File: rtl/baud_ctrl.sv
// baud_ctrl: runtime-selectable UART baud divider.
// Produces tick16 (16x oversample strobe), tick1 (bit strobe) and the legacy
// clkout16 square wave. The host changes the rate through a req/ack handshake
// and the new divisor only takes effect once both RX and TX are idle.
module baud_ctrl #(
    parameter logic [2:0] DEFAULT_SEL = 3'd1,
    parameter int         CNT_W       = 16
) (
    input  logic       clk50,
    input  logic       rst_n,
    input  logic       cfg_req,
    input  logic [2:0] cfg_sel,
    input  logic       busy_rx,
    input  logic       busy_tx,
    output logic       cfg_ack,
    output logic       cfg_err,
    output logic [2:0] cur_sel,
    output logic       tick16,
    output logic       tick1,
    output logic       clkout16
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PEND  = 2'd1;
    localparam logic [1:0] APPLY = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    // Divisor = round(50 MHz / (16 * baud)). Codes 6 and 7 are never applied.
    function automatic logic [CNT_W-1:0] div_of(input logic [2:0] s);
        case (s)
            3'd0:    div_of = CNT_W'(651);
            3'd1:    div_of = CNT_W'(326);
            3'd2:    div_of = CNT_W'(163);
            3'd3:    div_of = CNT_W'(81);
            3'd4:    div_of = CNT_W'(54);
            3'd5:    div_of = CNT_W'(27);
            default: div_of = CNT_W'(0);
        endcase
    endfunction

    function automatic logic sel_ok(input logic [2:0] s);
        sel_ok = (s < 3'd6);
    endfunction

    logic [1:0]       state;
    logic [2:0]       nsel;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       sub;
    logic [CNT_W-1:0] last;
    logic [CNT_W-1:0] half_m1;

    assign last    = div - CNT_W'(1);
    assign half_m1 = (div >> 1) - CNT_W'(1);

    // Divider: free-running counter; APPLY restarts the phase at the new divisor.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            div      <= div_of(DEFAULT_SEL);
            cnt      <= '0;
            sub      <= '0;
            tick16   <= 1'b0;
            tick1    <= 1'b0;
            clkout16 <= 1'b0;
        end else if (state == APPLY) begin
            div      <= div_of(nsel);
            cnt      <= '0;
            sub      <= '0;
            tick16   <= 1'b0;
            tick1    <= 1'b0;
            clkout16 <= 1'b0;
        end else begin
            tick16 <= 1'b0;
            tick1  <= 1'b0;
            if (cnt == last) begin
                cnt      <= '0;
                tick16   <= 1'b1;
                sub      <= sub + 4'd1;
                tick1    <= (sub == 4'd15);
                clkout16 <= 1'b0;
            end else begin
                cnt <= cnt + CNT_W'(1);
                if (cnt == half_m1)
                    clkout16 <= 1'b1;
            end
        end
    end

    // Config handshake FSM: latch request, wait for idle link, apply, ack once.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            nsel    <= DEFAULT_SEL;
            cur_sel <= DEFAULT_SEL;
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_err <= 1'b0;
                    if (cfg_req) begin
                        nsel  <= cfg_sel;
                        state <= PEND;
                    end
                end
                PEND: begin
                    if (!sel_ok(nsel)) begin
                        cfg_ack <= 1'b1;
                        cfg_err <= 1'b1;
                        state   <= ACK;
                    end else if (!busy_rx && !busy_tx) begin
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    cur_sel <= nsel;
                    cfg_ack <= 1'b1;
                    cfg_err <= 1'b0;
                    state   <= ACK;
                end
                default: begin
                    cfg_err <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_baud_ctrl.sv
// Self-checking bench for baud_ctrl: table of rate changes plus hand-written
// busy / double-request / reset sequences. Acks are checked against a
// scoreboard of expected {cycle, err, sel} pushed when stimulus is driven.
module tb_baud_ctrl;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_req = 1'b0;
    logic [2:0] cfg_sel = 3'd0;
    logic       busy_rx = 1'b0;
    logic       busy_tx = 1'b0;
    logic       cfg_ack, cfg_err, tick16, tick1, clkout16;
    logic [2:0] cur_sel;

    baud_ctrl #(.DEFAULT_SEL(3'd1), .CNT_W(16)) dut (
        .clk50(clk50), .rst_n(rst_n), .cfg_req(cfg_req), .cfg_sel(cfg_sel),
        .busy_rx(busy_rx), .busy_tx(busy_tx), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .cur_sel(cur_sel), .tick16(tick16), .tick1(tick1), .clkout16(clkout16)
    );

    always #10 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int ack_total = 0;
    int coinc_viol = 0;

    typedef struct {
        int         cyc;
        logic       err;
        logic [2:0] sel;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [2:0] sel;
        logic       err;
        logic [2:0] exp_sel;
        int         div;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Ack monitor / scoreboard consumer
    always @(negedge clk50) begin
        if (rst_n) begin
            if (tick1 && !tick16) coinc_viol++;
            if (cfg_ack) begin
                exp_t e;
                ack_total++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack at cycle %0d expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_err", int'(cfg_err), int'(e.err));
                    chk("ack_sel", int'(cur_sel), int'(e.sel));
                end
            end
        end
    end

    task automatic wait_tick(output int t);
        int n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!tick16 && n < 2000);
        if (!tick16) chk("tick16_timeout", 0, 1);
        t = cyc;
    endtask

    task automatic period(output int p);
        int t0, t1;
        wait_tick(t0);
        wait_tick(t1);
        p = t1 - t0;
    endtask

    task automatic wait_ack(output int t);
        int n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!cfg_ack && n < 3000);
        if (!cfg_ack) chk("ack_timeout", 0, 1);
        t = cyc;
    endtask

    task automatic do_req(input logic [2:0] s, output int n);
        @(posedge clk50);
        #1;
        cfg_sel = s;
        cfg_req = 1'b1;
        n = cyc;
        @(posedge clk50);
        #1;
        cfg_req = 1'b0;
    endtask

    task automatic push(input int c, input logic e, input logic [2:0] s);
        exp_t x;
        x.cyc = c;
        x.err = e;
        x.sel = s;
        sb.push_back(x);
    endtask

    initial begin
        int n, ta, t0, t1, p, hi, lo, base, k;

        vt[0] = '{3'd5, 1'b0, 3'd5, 27};
        vt[1] = '{3'd6, 1'b1, 3'd5, 27};
        vt[2] = '{3'd3, 1'b0, 3'd3, 81};
        vt[3] = '{3'd3, 1'b0, 3'd3, 81};
        vt[4] = '{3'd7, 1'b1, 3'd3, 81};
        vt[5] = '{3'd4, 1'b0, 3'd4, 54};
        vt[6] = '{3'd2, 1'b0, 3'd2, 163};

        // Reset state
        repeat (3) @(negedge clk50);
        chk("rst_tick16", int'(tick16), 0);
        chk("rst_tick1", int'(tick1), 0);
        chk("rst_clkout16", int'(clkout16), 0);
        chk("rst_ack", int'(cfg_ack), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_cur_sel", int'(cur_sel), 1);
        @(posedge clk50);
        #1 rst_n = 1'b1;

        // Default rate
        period(p);
        chk("def_tick16_period", p, 326);
        k = 0;
        while (tick1 !== 1'b1 && k < 12000) begin @(negedge clk50); k++; end
        t0 = cyc;
        k = 0;
        do begin @(negedge clk50); k++; end while (tick1 !== 1'b1 && k < 12000);
        chk("def_tick1_period", cyc - t0, 5216);
        k = 0;
        while (clkout16 && k < 2000) begin @(negedge clk50); k++; end
        while (!clkout16 && k < 2000) begin @(negedge clk50); k++; end
        hi = 0;
        while (clkout16 && hi < 2000) begin hi++; @(negedge clk50); end
        lo = 0;
        while (!clkout16 && lo < 2000) begin lo++; @(negedge clk50); end
        chk("clkout16_high", hi, 163);
        chk("clkout16_low", lo, 163);
        chk("def_cur_sel", int'(cur_sel), 1);

        // Table-driven rate changes
        for (int i = 0; i < 7; i++) begin
            wait_tick(t0);
            do_req(vt[i].sel, n);
            push(vt[i].err ? n + 2 : n + 3, vt[i].err, vt[i].exp_sel);
            wait_ack(ta);
            wait_tick(t1);
            if (vt[i].err)
                chk("invalid_phase_kept", (t1 - t0) % vt[i].div, 0);
            else
                chk("first_tick_after_ack", t1 - ta, vt[i].div);
            period(p);
            chk("tbl_period", p, vt[i].div);
            chk("tbl_cur_sel", int'(cur_sel), int'(vt[i].exp_sel));
        end

        // Busy TX holds off the apply; old rate (163) keeps running
        busy_tx = 1'b1;
        do_req(3'd0, n);
        period(p);
        chk("pend_old_period", p, 163);
        repeat (1000) @(posedge clk50);
        chk("pend_cur_sel", int'(cur_sel), 2);
        #1 busy_tx = 1'b0;
        push(cyc + 2, 1'b0, 3'd0);
        wait_ack(ta);
        period(p);
        chk("busy_new_period", p, 651);

        // Second request while pending is ignored; busy toggles
        base = ack_total;
        busy_rx = 1'b1;
        do_req(3'd2, n);
        do_req(3'd4, n);
        @(posedge clk50); #1 busy_tx = 1'b1; busy_rx = 1'b0;
        repeat (3) @(posedge clk50);
        #1 busy_tx = 1'b0; busy_rx = 1'b1;
        repeat (3) @(posedge clk50);
        #1 busy_rx = 1'b0;
        push(cyc + 2, 1'b0, 3'd2);
        wait_ack(ta);
        repeat (30) @(negedge clk50);
        chk("single_ack", ack_total - base, 1);
        chk("first_sel_used", int'(cur_sel), 2);
        chk("sb_empty", sb.size(), 0);

        // Reset during PEND drops the request
        base = ack_total;
        busy_rx = 1'b1;
        do_req(3'd3, n);
        repeat (5) @(posedge clk50);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk50);
        chk("rst_mid_cur_sel", int'(cur_sel), 1);
        chk("rst_mid_ack", int'(cfg_ack), 0);
        busy_rx = 1'b0;
        @(posedge clk50);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk50);
        chk("rst_no_ack", ack_total - base, 0);
        period(p);
        chk("rst_period", p, 326);
        chk("rst_cur_sel", int'(cur_sel), 1);

        chk("tick1_coincident", coinc_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
